// File: rtl/wishbone_slave_bridge.sv
// -----------------------------------------------------------------------------
// wishbone_slave_bridge
//   Wishbone slave front end that turns one bus cycle into one request toward a
//   simple ready/valid device port. A single transfer is in flight at a time;
//   stall_o is held while the bridge is busy.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   addr_i/data_i/sel_i/we_i/cyc_i/stb_i   Wishbone request
//   data_o/ack_o/err_o/stall_o             Wishbone response (data/ack/err registered)
//   device_req_o/device_ready_i            request handshake toward device
//   device_addr_o/wdata_o/be_o/we_o        captured request fields
//   device_rdata_i/device_rdata_valid_i    read response from device
// -----------------------------------------------------------------------------
module wishbone_slave_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              device_req_o,
    input  logic              device_ready_i,
    output logic [ADDR_W-1:0] device_addr_o,
    output logic [DATA_W-1:0] device_wdata_o,
    output logic [SEL_W-1:0]  device_be_o,
    output logic              device_we_o,
    input  logic [DATA_W-1:0] device_rdata_i,
    input  logic              device_rdata_valid_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_ERR,
        ST_DRAIN
    } state_t;

    // Counter expires on the cycle it holds TIMEOUT-1, i.e. after TIMEOUT cycles
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [SEL_W-1:0]    be_reg, be_next;
    logic                we_reg, we_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                timeout_hit;
    logic                counting;

    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign counting    = (state_reg == ST_REQ) || (state_reg == ST_WAIT) ||
                         (state_reg == ST_DRAIN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            we_reg    <= we_next;
            rdata_reg <= rdata_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        we_next    = we_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cyc_i && stb_i && !ack_reg && !err_reg) begin
                    addr_next  = addr_i;
                    wdata_next = data_i;
                    be_next    = sel_i;
                    we_next    = we_i;
                    if (sel_i == '0) begin
                        // Null transfer: terminate without touching the device
                        state_next = ST_RESP;
                        rdata_next = '0;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Master abort beats everything; handshake beats timeout
                if (!cyc_i) begin
                    state_next = ST_IDLE;
                end else if (device_ready_i) begin
                    if (we_reg) begin
                        state_next = ST_RESP;
                        rdata_next = '0;
                    end else if (device_rdata_valid_i) begin
                        state_next = ST_RESP;
                        rdata_next = device_rdata_i;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                    rdata_next = '0;
                end
            end
            ST_WAIT: begin
                // If the response lands in the abort cycle it is already consumed,
                // so there is nothing left to drain.
                if (!cyc_i) begin
                    state_next = device_rdata_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (device_rdata_valid_i) begin
                    state_next = ST_RESP;
                    rdata_next = device_rdata_i;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                    rdata_next = '0;
                end
            end
            ST_DRAIN: begin
                if (device_rdata_valid_i || timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Every transition restarts the counter, so entry to a counting state clears it
        if (counting && (state_next == state_reg)) begin
            cnt_next = cnt_reg + 16'd1;
        end else begin
            cnt_next = '0;
        end

        ack_next = (state_next == ST_RESP);
        err_next = (state_next == ST_ERR);
    end

    assign data_o         = rdata_reg;
    assign ack_o          = ack_reg;
    assign err_o          = err_reg;
    assign stall_o        = (state_reg != ST_IDLE);
    assign device_req_o   = (state_reg == ST_REQ);
    assign device_addr_o  = addr_reg;
    assign device_wdata_o = wdata_reg;
    assign device_be_o    = be_reg;
    assign device_we_o    = we_reg;

endmodule

// File: tb/tb_wishbone_slave_bridge.sv
// -----------------------------------------------------------------------------
// tb_wishbone_slave_bridge
//   Scoreboard bench: each issued transfer pushes its predicted bus termination
//   and predicted device request into queues; monitors pop and compare whenever
//   the bridge terminates a cycle or hands a request to the device.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wishbone_slave_bridge;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o, err_o, stall_o, device_req_o;
    logic        device_ready_i = 1'b0;
    logic [31:0] device_addr_o, device_wdata_o;
    logic [3:0]  device_be_o;
    logic        device_we_o;
    logic [31:0] device_rdata_i = '0;
    logic        device_rdata_valid_i = 1'b0;

    wishbone_slave_bridge #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_n),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o),
        .device_req_o(device_req_o), .device_ready_i(device_ready_i),
        .device_addr_o(device_addr_o), .device_wdata_o(device_wdata_o),
        .device_be_o(device_be_o), .device_we_o(device_we_o),
        .device_rdata_i(device_rdata_i), .device_rdata_valid_i(device_rdata_valid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { bit is_err; logic [31:0] data; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } dev_t;

    resp_t exp_q[$];
    dev_t  dev_q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn_id = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    resp_t mon_r;
    dev_t  mon_d;
    logic  prev_term = 1'b0;

    always @(negedge clk_i) begin
        if (rst_n) begin
            if (ack_o || err_o) begin
                chk("ack_err_exclusive", {63'd0, ack_o & err_o}, 64'd0);
                chk("term_one_cycle", {63'd0, prev_term}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_term", {63'd0, ack_o | err_o}, 64'd0);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("term_kind_err", {63'd0, err_o}, {63'd0, mon_r.is_err});
                    chk("data_o", {32'd0, data_o}, {32'd0, mon_r.data});
                    $display("txn resp: err=%0d data_o=%08h", err_o, data_o);
                end
            end
            if (device_req_o && device_ready_i) begin
                if (dev_q.size() == 0) begin
                    chk("unexpected_dev_req", {63'd0, device_req_o}, 64'd0);
                end else begin
                    mon_d = dev_q.pop_front();
                    chk("dev_addr", {32'd0, device_addr_o}, {32'd0, mon_d.addr});
                    chk("dev_wdata", {32'd0, device_wdata_o}, {32'd0, mon_d.wdata});
                    chk("dev_be", {60'd0, device_be_o}, {60'd0, mon_d.be});
                    chk("dev_we", {63'd0, device_we_o}, {63'd0, mon_d.we});
                end
            end
        end
        prev_term <= rst_n & (ack_o | err_o);
    end

    // ---------------- stimulus helpers ----------------
    // dr: REQ cycles with ready low before ready rises; dv: WAIT cycles before valid;
    // conc: valid presented together with ready.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int dr, input int dv,
                          input logic [31:0] rdata, input bit conc);
        resp_t r;
        dev_t  d;
        int    exp_lat;
        int    kr;
        int    kv;
        bit    done;
        r.is_err = 1'b0;
        r.data   = '0;
        if (sel == 4'd0)       begin exp_lat = 1; end
        else if (dr >= T)      begin r.is_err = 1'b1; exp_lat = T + 1; end
        else if (we)           begin exp_lat = dr + 2; end
        else if (conc)         begin r.data = rdata; exp_lat = dr + 2; end
        else if (dv >= T)      begin r.is_err = 1'b1; exp_lat = dr + T + 2; end
        else                   begin r.data = rdata; exp_lat = dr + dv + 3; end
        if (sel != 4'd0 && dr < T) begin
            d.addr = addr; d.wdata = wdata; d.be = sel; d.we = we;
            dev_q.push_back(d);
        end
        exp_q.push_back(r);
        txn_id++;

        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = addr; data_i = wdata; sel_i = sel;
        device_rdata_i = rdata;
        kr = 0; kv = 0; done = 1'b0;
        for (int it = 1; it <= 60 && !done; it++) begin
            @(posedge clk_i); #1;
            device_ready_i = 1'b0;
            device_rdata_valid_i = 1'b0;
            if (it == 1) chk("stall_after_capture", {63'd0, stall_o}, 64'd1);
            if (ack_o || err_o) begin
                cyc_i = 1'b0; stb_i = 1'b0;
                done = 1'b1;
                chk("latency", 64'(it), 64'(exp_lat));
            end else if (device_req_o) begin
                device_ready_i = (kr >= dr);
                device_rdata_valid_i = conc && (kr >= dr) && !we;
                kr++;
            end else begin
                device_rdata_valid_i = (kv == dv);
                kv++;
            end
        end
        if (!done) begin
            chk("txn_cycle_budget", 64'd0, 64'd1);
            cyc_i = 1'b0; stb_i = 1'b0;
        end
        $display("txn %0d: we=%0d addr=%08h sel=%0h dr=%0d dv=%0d conc=%0d", txn_id, we, addr, sel, dr, dv, conc);
    endtask

    // A response with no request outstanding must be ignored
    task automatic stray_valid();
        @(posedge clk_i); #1;
        device_rdata_i = 32'hBAD0BAD0;
        device_rdata_valid_i = 1'b1;
        @(posedge clk_i); #1;
        device_rdata_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_o"}, {32'd0, data_o}, 64'd0);
        chk({tag, "_ack"}, {63'd0, ack_o}, 64'd0);
        chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
        chk({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
        chk({tag, "_dev_req"}, {63'd0, device_req_o}, 64'd0);
        chk({tag, "_dev_fields"}, {device_addr_o, device_wdata_o} | {59'd0, device_be_o, device_we_o}, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        do_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1'b0);
        do_txn(1'b0, 32'h200, 32'h0, 4'hF, 3, 2, 32'h12345678, 1'b0);
        do_txn(1'b1, 32'h300, 32'h1, 4'hF, 100, 0, 32'h0, 1'b0);
        do_txn(1'b1, 32'h400, 32'h55, 4'h0, 0, 0, 32'h0, 1'b0);
        do_txn(1'b0, 32'h500, 32'h0, 4'h3, 1, 0, 32'hCAFEF00D, 1'b1);
        do_txn(1'b0, 32'h600, 32'h0, 4'hF, 0, 100, 32'h77, 1'b0);
        do_txn(1'b0, 32'h610, 32'h0, 4'hF, 3, 3, 32'h88, 1'b0);

        // Read abandoned in WAIT: late response must be swallowed
        dev_q.push_back('{addr: 32'h700, wdata: 32'h0, be: 4'hF, we: 1'b0});
        @(posedge clk_i); #1;
        cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 32'h700; data_i = 0; sel_i = 4'hF;
        device_rdata_i = 32'hBAD00001;
        @(posedge clk_i); #1; device_ready_i = 1'b1;
        @(posedge clk_i); #1; device_ready_i = 1'b0; cyc_i = 0; stb_i = 0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; device_rdata_valid_i = 1'b1;
        @(posedge clk_i); #1; device_rdata_valid_i = 1'b0;
        chk("drain_back_idle", {63'd0, stall_o}, 64'd0);
        $display("txn abort-in-wait: stall=%0d", stall_o);
        do_txn(1'b0, 32'h704, 32'h0, 4'hF, 0, 0, 32'hA5A5A5A5, 1'b0);

        // Write abandoned in REQ
        @(posedge clk_i); #1;
        cyc_i = 1; stb_i = 1; we_i = 1; addr_i = 32'h800; data_i = 32'h9; sel_i = 4'hF;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; cyc_i = 0; stb_i = 0;
        @(posedge clk_i); #1;
        chk("abort_req_idle", {63'd0, stall_o}, 64'd0);
        $display("txn abort-in-req: stall=%0d", stall_o);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) stray_valid();
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, s,
                   $urandom_range(0, 5), $urandom_range(0, 5), $urandom,
                   ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of WAIT
        dev_q.push_back('{addr: 32'h900, wdata: 32'h0, be: 4'hF, we: 1'b0});
        @(posedge clk_i); #1;
        cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 32'h900; data_i = 0; sel_i = 4'hF;
        @(posedge clk_i); #1; device_ready_i = 1'b1;
        @(posedge clk_i); #1; device_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        cyc_i = 0; stb_i = 0;
        @(posedge clk_i); #1; rst_n = 1'b1;
        $display("txn async-reset-mid-wait done");
        stray_valid();
        chk("after_reset_idle", {63'd0, stall_o}, 64'd0);
        do_txn(1'b1, 32'hA00, 32'h13579BDF, 4'h5, 0, 0, 32'h0, 1'b0);

        repeat (3) @(posedge clk_i);
        chk("resp_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("dev_queue_empty", 64'(dev_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/wishbone_slave_bridge.md
WISHBONE_SLAVE_BRIDGE -- requirements
Module: wishbone_slave_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the bus and device ports.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter SEL_W, default DATA_W/8, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent in REQ, WAIT or DRAIN before abort; range 1..65535.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 addr_i  in  ADDR_W  bus address.
REQ-008 data_i  in  DATA_W  bus write data.
REQ-009 data_o  out  DATA_W  bus read data, registered.
REQ-010 we_i  in  1  write enable.
REQ-011 sel_i  in  SEL_W  byte selects.
REQ-012 cyc_i, stb_i  in  1 each  cycle and strobe.
REQ-013 ack_o  out  1  normal termination, registered.
REQ-014 err_o  out  1  error termination, registered.
REQ-015 stall_o  out  1  bridge busy; high in every state except IDLE.
REQ-016 device_req_o  out  1  request valid toward device.
REQ-017 device_ready_i  in  1  device accepts request.
REQ-018 device_addr_o, device_wdata_o, device_be_o, device_we_o  out  ADDR_W/DATA_W/SEL_W/1  request fields, driven from capture registers.
REQ-019 device_rdata_i  in  DATA_W; device_rdata_valid_i  in  1  read response.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, RESP, ERR, DRAIN.
REQ-021 IDLE: cyc_i&stb_i&~ack_o&~err_o SHALL capture addr_i, data_i, sel_i, we_i; next state REQ, or RESP if sel_i==0 (null transfer, no device request).
REQ-022 REQ: device_req_o=1; on device_ready_i go RESP for writes, WAIT for reads; device_req_o low in all other states.
REQ-023 WAIT: on device_rdata_valid_i latch device_rdata_i into data_o, go RESP.
REQ-024 RESP: ack_o=1 for exactly one cycle, then IDLE; writes and null transfers drive data_o=0.
REQ-025 ERR: err_o=1 for exactly one cycle, data_o=0, then IDLE; ack_o and err_o never high together.
REQ-026 Latency: accepted write with ready held high gives ack_o 2 cycles after capture edge; read with ready and valid on consecutive cycles gives ack_o 3 cycles after capture.
REQ-027 Timeout counter cleared on entry to REQ, WAIT or DRAIN, incremented each cycle there; reaching TIMEOUT SHALL go ERR from REQ/WAIT, IDLE from DRAIN.
REQ-028 cyc_i low in REQ: IDLE, no ack. cyc_i low in WAIT: DRAIN; no ack or err.
REQ-029 DRAIN: discards next device_rdata_valid_i, then IDLE; new bus requests stalled meanwhile.
REQ-030 device_rdata_valid_i in IDLE, REQ, RESP, ERR SHALL be ignored.
REQ-031 device_ready_i and device_rdata_valid_i together in REQ for a read SHALL both be honoured: go RESP directly with data latched.
REQ-032 Timeout expiry and device handshake in the same cycle: handshake wins.

Reset
REQ-033 rst_i low SHALL immediately force IDLE, counter 0, ack_o=0, err_o=0, stall_o=0, device_req_o=0, data_o=0, capture registers 0, regardless of transfer in progress.
REQ-034 After rst_i rises the first request SHALL be accepted on the first clock edge seen with cyc_i&stb_i.

Verification
REQ-035 Write addr 0x100, data 0xDEADBEEF, sel 0xF, ready tied high -> device_req_o one cycle with those fields, ack_o 2 cycles after capture, data_o=0.
REQ-036 Read 0x200, ready after 3 cycles, rdata 0x12345678 valid 2 cycles later -> ack_o one cycle, data_o=0x12345678.
REQ-037 TIMEOUT=4, ready held low -> err_o one cycle after 4 cycles in REQ, no ack_o, IDLE afterwards.
REQ-038 Read, cyc_i dropped in WAIT, valid arrives 2 cycles later, then new read returns 0xA5A5A5A5 -> no ack for first, second acked with 0xA5A5A5A5.
REQ-039 sel_i=0 write -> ack_o next cycle, device_req_o never asserted.
REQ-040 rst_i pulsed low mid-WAIT, asynchronous to clk_i -> all outputs 0 immediately; late rdata_valid ignored.
